falling_edge_gen: RTL
=====================

# falling_edge_gen

Programmable falling-edge train generator: on a start request it drives `sig_out` through N high/low periods. The high and low durations are configurable in clock cycles, so each period ends in one clean, clock-aligned falling edge. It is the stimulus/transmit side of the team's falling-edge detection path. Typical uses: emulating an external strobe line and driving a downstream negative-edge detector. It reports progress through a busy/done handshake and a per-edge strobe.

## Interface
- `CNT_W`, default 16: width of the high/low duration fields (cycles).
- `NUM_W`, default 8: width of the edge-count field.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin a train; sampled only in IDLE.
- `high_cycles`  in  CNT_W  high time per period; sampled with `start`.
- `low_cycles`  in  CNT_W  low time per period; sampled with `start`.
- `num_edges`  in  NUM_W  number of falling edges to emit; sampled with `start`.
- `abort`  in  1  stop the train immediately (present only with `FALLING_EDGE_GEN_ABORT_EN`).
- `sig_out`  out  1  generated line; registered; idles high.
- `busy`  out  1  high while a train is in progress.
- `done`  out  1  one-cycle pulse when a train completes or is aborted.
- `edge_strobe`  out  1  one-cycle pulse in the first cycle each falling edge is visible on `sig_out`.

## Operation
- States: IDLE, HIGH, LOW.
- **Reset:** state IDLE, `sig_out`=1, `busy`=0, `done`=0, `edge_strobe`=0, all counters 0.
- **Accepting a request:** in IDLE with `start`=1 and `num_edges`≠0:
  - latch all three config inputs and clear the edge count;
  - enter HIGH and set `busy`=1.
- **Zero-length request:** in IDLE with `start`=1 and `num_edges`=0, pulse `done` on the next cycle. No edges are produced and `busy` stays 0.
- **Zero durations:** `high_cycles`=0 or `low_cycles`=0 is treated as 1. Arithmetic uses the effective value max(x,1).
- **HIGH:** `sig_out`=1 for exactly H effective cycles, then go to LOW.
- **LOW:**
  - `sig_out`=0 for exactly L effective cycles.
  - The edge count increments on entry, and `edge_strobe` pulses in that same first low cycle.
  - At the end of the phase, if count==N, return to IDLE; otherwise go back to HIGH.
- **Completion:** on the LOW→IDLE transition, `sig_out` returns to 1, `busy` falls and `done` pulses, all in the same cycle.
- Internal duration counters are CNT_W bits, and they do not wrap for any legal input.
- Changes on `start` or the config inputs while busy are ignored; the latched config is used for the whole train.
- Asserting `rst_n` at any point, including mid-train, returns immediately to reset values. The line then reads high, so no spurious falling edge is generated.

## Timing
- Let the edge at which `start` is accepted be t0.
- `busy`=1 from t0+1.
- Falling edge k (k=1..N) is first visible at cycle t0 + k·H + (k−1)·L + 1 after the edge. `edge_strobe` is high in that same cycle.
- `done`=1 and `sig_out`=1 at cycle t0 + N·(H+L) + 1. `busy` reads 0 from that cycle.
- A new `start` can be accepted in the same cycle `done` is high (back-to-back trains). The line then holds high for H cycles before the next edge.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `FALLING_EDGE_GEN_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in HIGH or LOW forces IDLE on the next edge: `sig_out`=1, `busy`=0, `done` pulses once.
  - No `edge_strobe` is generated on that cycle.
  - `abort` in IDLE is ignored.
  - If `abort` and completion coincide, there is exactly one `done`.
- Not defined: the `abort` port is absent and the train always runs to completion.

## Test plan
- **Reset values:** reset, then release. `sig_out`=1, `busy`=0, `done`=0, `edge_strobe`=0 for 20 idle cycles.
- **Basic train:** start with H=3, L=2, N=4.
  - Exactly 4 falling edges, at t0+4, t0+9, t0+14, t0+19.
  - 4 `edge_strobe` pulses, aligned with those edges.
  - `done` at t0+21; `busy` high for 20 cycles.
- **Boundaries:** H=0, L=0, N=1 behaves as H=1, L=1.
  - One edge at t0+2, `done` at t0+3.
  - Separately, N=0 gives `done` at t0+1 with no edge and `busy` never high.
- **Ignored and back-to-back starts:** pulse `start` with new config mid-train, and the train is unchanged. Then issue `start` coincident with `done`, and the second train begins with no extra idle cycle and a correct first edge.
- **Reset mid-train:** assert `rst_n`=0 during LOW of a H=5, L=5, N=3 train. `sig_out`=1 asynchronously, no further strobes, and no `done`.
- **Abort (`FALLING_EDGE_GEN_ABORT_EN`):** abort during the 2nd HIGH of a N=5 train.
  - `sig_out` stays 1, with no rising glitch.
  - One `done` pulse, `busy` falls next cycle, and the edge count observed is 1.

Source files
------------

// File: rtl/falling_edge_gen.sv
// Programmable falling-edge train generator: N periods of H cycles high then L cycles low.
// Optional abort input enabled by defining FALLING_EDGE_GEN_ABORT_EN.
module falling_edge_gen #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] num_edges,
`ifdef FALLING_EDGE_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             sig_out,
    output logic             busy,
    output logic             done,
    output logic             edge_strobe,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] hi_len, hi_next;
    logic [CNT_W-1:0] lo_len, lo_next;
    logic [NUM_W-1:0] num_len, num_next;
    logic [NUM_W-1:0] edge_cnt, edge_next;
    logic             done_q, done_next;
    logic             strobe_q, strobe_next;
    logic             abort_req;

`ifdef FALLING_EDGE_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // A zero duration is treated as a single cycle.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] x);
        return (x == '0) ? CNT_W'(1) : x;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_len   <= '0;
            lo_len   <= '0;
            num_len  <= '0;
            edge_cnt <= '0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            hi_len   <= hi_next;
            lo_len   <= lo_next;
            num_len  <= num_next;
            edge_cnt <= edge_next;
            done_q   <= done_next;
            strobe_q <= strobe_next;
        end
    end

    // cnt holds the remaining cycles of the current phase minus one.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        hi_next     = hi_len;
        lo_next     = lo_len;
        num_next    = num_len;
        edge_next   = edge_cnt;
        done_next   = 1'b0;
        strobe_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_edges == '0) begin
                        done_next = 1'b1;
                    end else begin
                        hi_next    = eff_len(high_cycles);
                        lo_next    = eff_len(low_cycles);
                        num_next   = num_edges;
                        edge_next  = '0;
                        cnt_next   = eff_len(high_cycles) - CNT_W'(1);
                        state_next = HIGH;
                    end
                end
            end
            HIGH: begin
                if (abort_req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else if (cnt == '0) begin
                    state_next  = LOW;
                    cnt_next    = lo_len - CNT_W'(1);
                    edge_next   = edge_cnt + NUM_W'(1);
                    strobe_next = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            LOW: begin
                if (abort_req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else if (cnt == '0) begin
                    if (edge_cnt == num_len) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = HIGH;
                        cnt_next   = hi_len - CNT_W'(1);
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so reset forces the line high at once.
    always_comb begin
        sig_out     = (state != LOW);
        busy        = (state != IDLE);
        done        = done_q;
        edge_strobe = strobe_q;
        state_dbg   = state;
    end

endmodule
